vec_sub_seq: RTL and testbench

VEC_SUB_SEQ -- requirements
Module: vec_sub_seq

---
 rtl/vec_sub_seq.sv | 200 ++++++++++++++++++++
 tb/tb_vec_sub_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_sub_seq.sv
// vec_sub_seq
//   Feeds an N_COMP-component single-precision vector pair, one component
//   at a time, through an external FP subtractor and reassembles the
//   results into one output vector.  No arithmetic happens here; the
//   subtractor result words are stored exactly as returned.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_a, in_b, in_swap      operand vectors (component k at [32k+31:32k]) and
//                            swap select (1: in_b - in_a)
//   in_stb / in_ack          input vector handshake
//   sub_a, sub_a_stb/_ack    operand A word to the subtractor
//   sub_b, sub_b_stb/_ack    operand B word to the subtractor
//   sub_z, sub_z_stb/_ack    result word from the subtractor
//   out_vec, out_stb/_ack    result vector handshake
//   busy                     high whenever the sequencer is not idle
module vec_sub_seq #(
  parameter int N_COMP = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [32*N_COMP-1:0] in_a,
  input  logic [32*N_COMP-1:0] in_b,
  input  logic                 in_swap,
  input  logic                 in_stb,
  output logic                 in_ack,
  output logic [31:0]          sub_a,
  output logic [31:0]          sub_b,
  output logic                 sub_a_stb,
  output logic                 sub_b_stb,
  input  logic                 sub_a_ack,
  input  logic                 sub_b_ack,
  input  logic [31:0]          sub_z,
  input  logic                 sub_z_stb,
  output logic                 sub_z_ack,
  output logic [32*N_COMP-1:0] out_vec,
  output logic                 out_stb,
  input  logic                 out_ack,
  output logic                 busy
);

  localparam int IDX_W = (N_COMP > 1) ? $clog2(N_COMP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COMP - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEND_A  = 3'd1;
  localparam logic [2:0] SEND_B  = 3'd2;
  localparam logic [2:0] WAIT_Z  = 3'd3;
  localparam logic [2:0] PUT_OUT = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    idx_inc;
  logic                in_ack_q, in_ack_d;
  logic                sub_a_stb_q, sub_a_stb_d;
  logic                sub_b_stb_q, sub_b_stb_d;
  logic                sub_z_ack_q, sub_z_ack_d;
  logic                out_stb_q, out_stb_d;
  logic                busy_q, busy_d;
  logic [31:0]         sub_a_q, sub_a_d;
  logic [31:0]         sub_b_q, sub_b_d;
  logic [32*N_COMP-1:0] out_vec_q, out_vec_d;

  logic                swap_q;
  logic [31:0]         a_q   [N_COMP];
  logic [31:0]         b_q   [N_COMP];
  logic [31:0]         res_q [N_COMP];

  logic                accept;
  logic                z_take;

  assign accept  = (state_q == IDLE) && in_ack_q && in_stb;
  assign z_take  = (state_q == WAIT_Z) && sub_z_stb && sub_z_ack_q;
  assign idx_inc = idx_q + 1'b1;

  // Sequencer: next-state and registered-output values
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_ack_d    = in_ack_q;
    sub_a_stb_d = sub_a_stb_q;
    sub_b_stb_d = sub_b_stb_q;
    sub_z_ack_d = sub_z_ack_q;
    out_stb_d   = out_stb_q;
    sub_a_d     = sub_a_q;
    sub_b_d     = sub_b_q;
    out_vec_d   = out_vec_q;

    case (state_q)
      IDLE: begin
        in_ack_d = 1'b1;
        if (accept) begin
          in_ack_d    = 1'b0;
          idx_d       = '0;
          sub_a_stb_d = 1'b1;
          // Operand words come straight from the inputs being latched now.
          sub_a_d     = in_swap ? in_b[31:0] : in_a[31:0];
          state_d     = SEND_A;
        end
      end
      SEND_A: begin
        if (sub_a_stb_q && sub_a_ack) begin
          sub_a_stb_d = 1'b0;
          sub_b_stb_d = 1'b1;
          sub_b_d     = swap_q ? a_q[idx_q] : b_q[idx_q];
          state_d     = SEND_B;
        end
      end
      SEND_B: begin
        if (sub_b_stb_q && sub_b_ack) begin
          sub_b_stb_d = 1'b0;
          sub_z_ack_d = 1'b1;
          state_d     = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (z_take) begin
          sub_z_ack_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            // The last result is merged directly from sub_z; its slot in
            // res_q is only written on this same edge.
            for (int k = 0; k < N_COMP; k++) begin
              out_vec_d[32*k +: 32] = (IDX_W'(k) == idx_q) ? sub_z : res_q[k];
            end
            out_stb_d = 1'b1;
            state_d   = PUT_OUT;
          end else begin
            idx_d       = idx_inc;
            sub_a_stb_d = 1'b1;
            sub_a_d     = swap_q ? b_q[idx_inc] : a_q[idx_inc];
            state_d     = SEND_A;
          end
        end
      end
      PUT_OUT: begin
        if (out_stb_q && out_ack) begin
          out_stb_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      in_ack_q    <= 1'b0;
      sub_a_stb_q <= 1'b0;
      sub_b_stb_q <= 1'b0;
      sub_z_ack_q <= 1'b0;
      out_stb_q   <= 1'b0;
      busy_q      <= 1'b0;
      sub_a_q     <= '0;
      sub_b_q     <= '0;
      out_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ack_q    <= in_ack_d;
      sub_a_stb_q <= sub_a_stb_d;
      sub_b_stb_q <= sub_b_stb_d;
      sub_z_ack_q <= sub_z_ack_d;
      out_stb_q   <= out_stb_d;
      busy_q      <= busy_d;
      sub_a_q     <= sub_a_d;
      sub_b_q     <= sub_b_d;
      out_vec_q   <= out_vec_d;
    end
  end

  // Operand and partial-result storage
  always_ff @(posedge clk) begin
    if (accept) begin
      swap_q <= in_swap;
      for (int k = 0; k < N_COMP; k++) begin
        a_q[k] <= in_a[32*k +: 32];
        b_q[k] <= in_b[32*k +: 32];
      end
    end
    if (z_take) begin
      res_q[idx_q] <= sub_z;
    end
  end

  assign in_ack    = in_ack_q;
  assign sub_a     = sub_a_q;
  assign sub_b     = sub_b_q;
  assign sub_a_stb = sub_a_stb_q;
  assign sub_b_stb = sub_b_stb_q;
  assign sub_z_ack = sub_z_ack_q;
  assign out_vec   = out_vec_q;
  assign out_stb   = out_stb_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vec_sub_seq.sv
// Bench for vec_sub_seq: plays the upstream source, a stand-in FP subtractor
// with random handshake delays, and the downstream sink.
module tb_vec_sub_seq;

  localparam int N  = 3;
  localparam int VW = 32 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] in_a, in_b;
  logic          in_swap, in_stb, in_ack;
  logic [31:0]   sub_a, sub_b, sub_z;
  logic          sub_a_stb, sub_b_stb, sub_a_ack, sub_b_ack;
  logic          sub_z_stb, sub_z_ack;
  logic [VW-1:0] out_vec;
  logic          out_stb, out_ack, busy;

  always #5 clk = ~clk;

  vec_sub_seq #(.N_COMP(N)) dut (
    .clk(clk), .rst(rst),
    .in_a(in_a), .in_b(in_b), .in_swap(in_swap), .in_stb(in_stb), .in_ack(in_ack),
    .sub_a(sub_a), .sub_b(sub_b), .sub_a_stb(sub_a_stb), .sub_b_stb(sub_b_stb),
    .sub_a_ack(sub_a_ack), .sub_b_ack(sub_b_ack),
    .sub_z(sub_z), .sub_z_stb(sub_z_stb), .sub_z_ack(sub_z_ack),
    .out_vec(out_vec), .out_stb(out_stb), .out_ack(out_ack), .busy(busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Stand-in subtractor: exact IEEE results for the directed operand pairs,
  // an asymmetric scramble for anything else (the block under test only
  // routes words, so any deterministic function exposes routing errors).
  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case ({a, b})
      {32'h3F800000, 32'h3F000000}: r = 32'h3F000000;
      {32'h40000000, 32'h3F000000}: r = 32'h3FC00000;
      {32'h40400000, 32'h3F000000}: r = 32'h40200000;
      {32'h3F000000, 32'h3F800000}: r = 32'hBF000000;
      {32'h3F000000, 32'h40000000}: r = 32'hBFC00000;
      {32'h3F000000, 32'h40400000}: r = 32'hC0200000;
      {32'h7F800000, 32'h7F800000}: r = 32'h7FC00000;
      {32'h00000000, 32'h00000000}: r = 32'h00000000;
      {32'h40000000, 32'h3F800000}: r = 32'h3F800000;
      default:                      r = a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0001;
    endcase
    return r;
  endfunction

  // Whole-vector expectation: component k is minuend[k] - subtrahend[k].
  function automatic logic [VW-1:0] model_vec(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                             input logic sw);
    logic [VW-1:0] r;
    for (int k = 0; k < N; k++) begin
      r[32*k +: 32] = sw ? fp_sub(b[32*k +: 32], a[32*k +: 32])
                         : fp_sub(a[32*k +: 32], b[32*k +: 32]);
    end
    return r;
  endfunction

  // Shared between monitor (negedge) and drivers (posedge + 1).
  logic [31:0]   exp_a_q [$];
  logic [31:0]   exp_b_q [$];
  logic [VW-1:0] exp_out_q [$];
  bit            xin, xa, xb, xz, xout;
  bit            r_flag = 1'b1;
  logic [31:0]   cap_a, cap_b;
  int            nb_cnt;
  bit            pa_stb, pb_stb, pz_ack, po_stb;
  logic [31:0]   pa_val, pb_val;
  logic [VW-1:0] po_val;

  // Monitor and model: flags describe the transfer at the coming posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_a_q.delete();
        exp_b_q.delete();
        exp_out_q.delete();
        xin = 0; xa = 0; xb = 0; xz = 0; xout = 0;
        pa_stb = 0; pb_stb = 0; pz_ack = 0; po_stb = 0;
        nb_cnt = 0;
        r_flag = 1'b1;
      end else begin
        r_flag = 1'b0;
        if (pa_stb && !xa) begin
          chk1("stall sub_a_stb", sub_a_stb, 1'b1);
          chk32("stall sub_a", sub_a, pa_val);
        end
        if (pb_stb && !xb) begin
          chk1("stall sub_b_stb", sub_b_stb, 1'b1);
          chk32("stall sub_b", sub_b, pb_val);
        end
        if (pz_ack && !xz) chk1("stall sub_z_ack", sub_z_ack, 1'b1);
        if (po_stb && !xout) begin
          chk1("stall out_stb", out_stb, 1'b1);
          chkv("stall out_vec", out_vec, po_val);
        end
        chk1("strobe exclusivity",
             $countones({in_ack, sub_a_stb, sub_b_stb, sub_z_ack, out_stb}) <= 1, 1'b1);
        chk1("in_ack with busy", in_ack && busy, 1'b0);

        xin = in_stb && in_ack;
        if (xin) begin
          for (int k = 0; k < N; k++) begin
            exp_a_q.push_back(in_swap ? in_b[32*k +: 32] : in_a[32*k +: 32]);
            exp_b_q.push_back(in_swap ? in_a[32*k +: 32] : in_b[32*k +: 32]);
          end
          exp_out_q.push_back(model_vec(in_a, in_b, in_swap));
          nb_cnt = 0;
        end
        xa = sub_a_stb && sub_a_ack;
        if (xa) begin
          cap_a = sub_a;
          if (exp_a_q.size() == 0) fail_now("sub_a transfer with no pending component");
          else chk32("sub_a order", sub_a, exp_a_q.pop_front());
        end
        xb = sub_b_stb && sub_b_ack;
        if (xb) begin
          cap_b = sub_b;
          nb_cnt++;
          if (exp_b_q.size() == 0) fail_now("sub_b transfer with no pending component");
          else chk32("sub_b order", sub_b, exp_b_q.pop_front());
        end
        xz = sub_z_stb && sub_z_ack;
        xout = out_stb && out_ack;
        if (xout) begin
          if (exp_out_q.size() == 0) fail_now("out_vec transfer with no pending vector");
          else chkv("out_vec model", out_vec, exp_out_q.pop_front());
        end
        pa_stb = sub_a_stb; pa_val = sub_a;
        pb_stb = sub_b_stb; pb_val = sub_b;
        pz_ack = sub_z_ack;
        po_stb = out_stb;   po_val = out_vec;
      end
    end
  end

  // Subtractor stand-in with 0..4 cycle random delays on each handshake.
  int          wa, wb, wz;
  bit          pend;
  logic [31:0] zval;

  initial begin
    sub_a_ack = 0; sub_b_ack = 0; sub_z_stb = 0; sub_z = '0;
    wa = 0; wb = 0; wz = 0; pend = 0; zval = '0;
    forever begin
      @(posedge clk);
      #1;
      if (r_flag) begin
        sub_a_ack = 0; sub_b_ack = 0; sub_z_stb = 0; pend = 0;
        wa = int'($urandom_range(0, 4));
        wb = int'($urandom_range(0, 4));
      end else begin
        if (xa) begin
          sub_a_ack = 0;
          wa = int'($urandom_range(0, 4));
        end else if (sub_a_stb && !sub_a_ack) begin
          if (wa == 0) sub_a_ack = 1; else wa--;
        end
        if (xb) begin
          sub_b_ack = 0;
          wb = int'($urandom_range(0, 4));
          pend = 1;
          zval = fp_sub(cap_a, cap_b);
          wz = int'($urandom_range(0, 4));
        end else if (sub_b_stb && !sub_b_ack) begin
          if (wb == 0) sub_b_ack = 1; else wb--;
        end
        if (xz) begin
          sub_z_stb = 0;
          pend = 0;
        end else if (pend && !sub_z_stb) begin
          if (wz == 0) begin
            sub_z_stb = 1;
            sub_z = zval;
          end else wz--;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk1({tag, " in_ack"}, in_ack, 1'b0);
    chk1({tag, " sub_a_stb"}, sub_a_stb, 1'b0);
    chk1({tag, " sub_b_stb"}, sub_b_stb, 1'b0);
    chk1({tag, " sub_z_ack"}, sub_z_ack, 1'b0);
    chk1({tag, " out_stb"}, out_stb, 1'b0);
    chk1({tag, " busy"}, busy, 1'b0);
    chk32({tag, " sub_a"}, sub_a, 32'h0);
    chk32({tag, " sub_b"}, sub_b, 32'h0);
    chkv({tag, " out_vec"}, out_vec, '0);
  endtask

  // One complete vector with the result held unacknowledged for 'hold' cycles.
  task automatic send_vec(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic sw,
                          input int hold, output logic [VW-1:0] got);
    int n;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_swap = sw; in_stb = 1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!xin && n < 200);
    in_stb = 0;
    if (!xin) fail_now("timeout waiting for in_ack");
    n = 0;
    while (!out_stb && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!out_stb) fail_now("timeout waiting for out_stb");
    got = out_vec;
    chkv("out_vec vs model", got, model_vec(a, b, sw));
    repeat (hold) begin
      @(posedge clk); #1;
      chk1("held out_stb", out_stb, 1'b1);
      chkv("held out_vec", out_vec, got);
      chk1("held in_ack", in_ack, 1'b0);
    end
    out_ack = 1;
    @(posedge clk); #1;
    out_ack = 0;
    chk1("out_stb after ack", out_stb, 1'b0);
    chk1("in_ack first edge after out ack", in_ack, 1'b0);
    chk1("busy after out ack", busy, 1'b0);
    @(posedge clk); #1;
    chk1("in_ack second edge after out ack", in_ack, 1'b1);
  endtask

  localparam logic [VW-1:0] A0 = {32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [VW-1:0] B0 = {32'h3F000000, 32'h3F000000, 32'h3F000000};
  localparam logic [VW-1:0] A1 = {32'h40000000, 32'h00000000, 32'h7F800000};
  localparam logic [VW-1:0] B1 = {32'h3F800000, 32'h00000000, 32'h7F800000};

  initial begin
    logic [VW-1:0] got, ra, rb;
    int n, cnt;
    rst = 1; in_a = '0; in_b = '0; in_swap = 0; in_stb = 0; out_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;
    @(posedge clk); #1;
    chk1("in_ack after reset release", in_ack, 1'b1);

    send_vec(A0, B0, 1'b0, 0, got);
    chkv("directed swap0", got, {32'h40200000, 32'h3FC00000, 32'h3F000000});
    send_vec(A0, B0, 1'b1, 5, got);
    chkv("directed swap1", got, {32'hC0200000, 32'hBFC00000, 32'hBF000000});

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) begin
        ra[32*k +: 32] = $urandom;
        rb[32*k +: 32] = $urandom;
      end
      send_vec(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), got);
    end

    // Reset while component 1 is waiting for its result.
    @(posedge clk); #1;
    in_a = A0; in_b = B0; in_swap = 0; in_stb = 1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!xin && n < 200);
    in_stb = 0;
    if (!xin) fail_now("timeout waiting for in_ack before mid-vector reset");
    n = 0;
    while (!(nb_cnt == 2 && sub_z_ack) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!(nb_cnt == 2 && sub_z_ack)) fail_now("timeout reaching component 1 result wait");
    chk1("busy before mid-vector reset", busy, 1'b1);
    rst = 1;
    @(posedge clk); #1;
    check_reset_outputs("mid-vector reset");
    rst = 0;
    @(posedge clk); #1;
    chk1("in_ack after mid-vector reset", in_ack, 1'b1);
    send_vec(A1, B1, 1'b0, 1, got);
    chkv("directed specials", got, {32'h3F800000, 32'h00000000, 32'h7FC00000});

    // Back-to-back vectors with in_stb never dropped.
    out_ack = 1;
    for (int k = 0; k < N; k++) begin
      in_a[32*k +: 32] = $urandom;
      in_b[32*k +: 32] = $urandom;
    end
    in_swap = 1'($urandom_range(0, 1));
    in_stb = 1;
    cnt = 0; n = 0;
    while (cnt < 6 && n < 2000) begin
      @(posedge clk); #1; n++;
      if (xin) begin
        cnt++;
        for (int k = 0; k < N; k++) begin
          in_a[32*k +: 32] = $urandom;
          in_b[32*k +: 32] = $urandom;
        end
        in_swap = 1'($urandom_range(0, 1));
      end
    end
    in_stb = 0;
    if (cnt < 6) fail_now("timeout in back-to-back acceptance");
    n = 0;
    while (exp_out_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    out_ack = 0;
    chk1("all back-to-back vectors delivered", exp_out_q.size() == 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk1("idle at end", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
